lokalizacja_bitu: RTL and testbench
===================================

// Module: lokalizacja_bitu
// PURPOSE
//  Sequential bit locator for the arithmetic unit; inverse of the bit-set op.
//  Given a word, scans it serially and returns the index of its lowest set bit.
//  Sits beside the combinational bit ops; start/busy/valid handshake to unit control.
//  All-zero word reports an error instead of an index.
// PARAMETERS
//  BITS   32   operand width; must be >= 2
//  IDX_W  $clog2(BITS)   localparam: width of the internal index counter
// PORTS
//  i_clk     in   1     clock; all state updates on rising edge
//  i_rst_n   in   1     reset, asynchronous, active-low
//  i_start   in   1     request; sampled only when o_busy=0
//  i_arg_A   in   BITS  signed word to scan; captured on accepted i_start
//  o_result  out  BITS  signed; zero-extended index of lowest set bit
//  o_error   out  1     1 = captured word was all zeros
//  o_busy    out  1     1 in SCAN and DONE; new requests ignored
//  o_valid   out  1     one-cycle pulse; o_result/o_error valid from this cycle
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, o_result=0, o_error=0, o_busy=0,
//   o_valid=0, shift reg=0, counter=0, found=0. Reset mid-scan aborts; no o_valid.
//  FSM IDLE -> SCAN -> DONE -> IDLE.
//  IDLE: i_start=1 -> capture i_arg_A into shift reg, cnt=0, found=0, -> SCAN.
//   i_start=0 -> stay. o_result/o_error hold last values.
//  SCAN: test shreg[0]; if 1 and !found -> idx=cnt, found=1. shreg >>= 1, cnt++.
//   Leave to DONE after bit BITS-1 is tested (see CONFIGURATION for early exit).
//  DONE: o_valid=1 for exactly this cycle; o_result = found ? idx : 0;
//   o_error = !found. Next cycle -> IDLE; results held until next accepted start.
//  i_start during SCAN/DONE: ignored, no queueing; i_arg_A changes ignored.
//  Back-to-back: i_start may be high in the cycle after DONE (IDLE) -> accepted.
//  Latency (start edge to o_valid cycle): BITS+1 cycles, data-independent.
//  Counter never wraps: terminal at BITS-1; no out-of-range index produced.
//  Sign of i_arg_A irrelevant: MSB treated as ordinary bit BITS-1.
// CONFIGURATION
//  `LOKALIZACJA_EARLY_EXIT_EN defined: SCAN -> DONE in the same edge that finds
//   the first set bit; latency = k+2 for lowest set index k. Zero word still
//   scans all BITS bits (latency BITS+1, o_error=1).
//  Not defined: fixed BITS+1 latency for every operand, as above.
//  Results (o_result, o_error) identical in both builds; only timing differs.
// STRUCTURE
//  Shared arith package: typedef enum logic [1:0] {IDLE, SCAN, DONE} for the FSM
//   state; BITS default and IDX_W helper constant.
//  Single module; no sub-module (shift reg, counter, FSM are too small to split).
// TESTING  (BITS=32; latency as fixed / early-exit)
//  A=32'h0000_0001 -> o_result=0, o_error=0; o_valid at 33 / 2 cycles.
//  A=32'h8000_0000 -> o_result=31, o_error=0; o_valid at 33 / 33 cycles.
//  A=32'h0000_0000 -> o_result=0, o_error=1; o_valid at 33 / 33 cycles.
//  A=32'h0001_0100 -> o_result=8 (lowest), o_error=0; 33 / 10 cycles.
//  i_start with A=32'h4 pulsed again mid-scan with A=32'h1 -> single o_valid, result 2.
//  i_rst_n low mid-scan -> all outputs 0 immediately, no o_valid; next start works.

Source files
------------

// File: rtl/lokalizacja_bitu_pkg.sv
// Shared arithmetic-unit definitions for the sequential bit locator:
// FSM state encoding, default operand width and index-width helper.
package lokalizacja_bitu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } lb_state_t;

    localparam int unsigned LB_BITS_DEFAULT  = 32;
    localparam int unsigned LB_IDX_W_DEFAULT = $clog2(LB_BITS_DEFAULT);

endpackage : lokalizacja_bitu_pkg

// File: rtl/lokalizacja_bitu.sv
// Sequential lowest-set-bit locator with start/busy/valid handshake.
// Optional: define LOKALIZACJA_EARLY_EXIT_EN to finish the scan at the first set bit.
module lokalizacja_bitu
    import lokalizacja_bitu_pkg::*;
#(
    parameter int unsigned BITS = LB_BITS_DEFAULT
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic signed [BITS-1:0] i_arg_A,
    output logic signed [BITS-1:0] o_result,
    output logic                   o_error,
    output logic                   o_busy,
    output logic                   o_valid
);

    localparam int unsigned IDX_W = $clog2(BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BITS - 1);

    lb_state_t              r_state;
    lb_state_t              w_next_state;
    logic [BITS-1:0]        r_shreg;
    logic [IDX_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_found;
    logic signed [BITS-1:0] r_result;
    logic                   r_error;
    logic                   r_valid;

    logic                   w_last;
    logic                   w_hit;
    logic                   w_found_now;
    logic [IDX_W-1:0]       w_idx_now;
    logic                   w_finish;

    assign w_last      = (r_cnt == LAST_IDX);
    assign w_hit       = r_shreg[0] & ~r_found;
    // Result of the scan including the bit tested in this very cycle.
    assign w_found_now = r_found | r_shreg[0];
    assign w_idx_now   = r_found ? r_idx : r_cnt;
    assign w_finish    = (r_state == SCAN) && (w_next_state == DONE);

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_next_state = SCAN;
                end
            end
            SCAN: begin
`ifdef LOKALIZACJA_EARLY_EXIT_EN
                if (w_hit || w_last) begin
                    w_next_state = DONE;
                end
`else
                if (w_last) begin
                    w_next_state = DONE;
                end
`endif
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shreg <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_found <= 1'b0;
        end else begin
            if (r_state == IDLE && i_start) begin
                r_shreg <= i_arg_A;
                r_cnt   <= '0;
                r_idx   <= '0;
                r_found <= 1'b0;
            end else if (r_state == SCAN) begin
                if (w_hit) begin
                    r_idx   <= r_cnt;
                    r_found <= 1'b1;
                end
                r_shreg <= r_shreg >> 1;
                // Counter saturates at the top index so it never wraps.
                if (!w_last) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_result <= '0;
            r_error  <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= w_finish;
            if (w_finish) begin
                r_result <= w_found_now ? BITS'(w_idx_now) : '0;
                r_error  <= ~w_found_now;
            end
        end
    end

    assign o_result = r_result;
    assign o_error  = r_error;
    assign o_valid  = r_valid;
    assign o_busy   = (r_state != IDLE);

endmodule : lokalizacja_bitu

// File: tb/tb_lokalizacja_bitu.sv
// Self-checking bench for lokalizacja_bitu (BITS=32), table vectors, random
// operands against a reference model, and hand-written multi-cycle sequences.
module tb_lokalizacja_bitu;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic signed [31:0] arg;
    logic signed [31:0] result;
    logic               error;
    logic               busy;
    logic               valid;

    int unsigned errors = 0;
    int unsigned checks = 0;

    lokalizacja_bitu #(.BITS(32)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_arg_A  (arg),
        .o_result (result),
        .o_error  (error),
        .o_busy   (busy),
        .o_valid  (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [31:0] arg;
        logic [31:0] exp_res;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: lowest set bit by direct search; latency from the timing rules.
    function automatic void ref_model(input logic [31:0] a, output int idx,
                                      output bit zero, output int lat);
        idx  = 0;
        zero = 1'b1;
        for (int i = 31; i >= 0; i--) begin
            if (a[i]) begin
                idx  = i;
                zero = 1'b0;
            end
        end
`ifdef LOKALIZACJA_EARLY_EXIT_EN
        lat = zero ? 33 : idx + 2;
`else
        lat = 33;
`endif
    endfunction

    task automatic run_op(input logic [31:0] a, output int lat,
                          output logic [31:0] res, output logic err);
        int n;
        @(negedge clk);
        arg   = a;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        arg   = $urandom;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("no_valid_after_start", {31'd0, valid}, 32'd0);
        n = 1;
        while (n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (valid) break;
        end
        if (!valid) begin
            errors++;
            checks++;
            $display("FAIL valid_timeout: got no o_valid, expected within 100 cycles");
        end
        lat = n;
        res = result;
        err = error;
        check("busy_in_done", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("valid_one_cycle", {31'd0, valid}, 32'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("result_held", result, res);
        check("error_held", {31'd0, error}, {31'd0, err});
    endtask

    vec_t        vecs[8];
    int          lat;
    logic [31:0] res;
    logic        err;
    int          m_idx;
    bit          m_zero;
    int          m_lat;
    int          nvalid;
    logic [31:0] cap_res;
    logic        cap_err;
    int          gap;

    initial begin
        vecs[0] = '{32'h0000_0001, 32'd0,  1'b0};
        vecs[1] = '{32'h8000_0000, 32'd31, 1'b0};
        vecs[2] = '{32'h0000_0000, 32'd0,  1'b1};
        vecs[3] = '{32'h0001_0100, 32'd8,  1'b0};
        vecs[4] = '{32'hFFFF_FFFF, 32'd0,  1'b0};
        vecs[5] = '{32'h4000_0000, 32'd30, 1'b0};
        vecs[6] = '{32'h0000_0006, 32'd1,  1'b0};
        vecs[7] = '{32'h8000_0001, 32'd0,  1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        arg   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_result", result, 32'd0);
        check("reset_error", {31'd0, error}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_valid", {31'd0, valid}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            ref_model(vecs[i].arg, m_idx, m_zero, m_lat);
            run_op(vecs[i].arg, lat, res, err);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
            check($sformatf("vec%0d_error", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
            check($sformatf("vec%0d_latency", i), lat, m_lat);
        end

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = $urandom;
            if (i % 4 == 1) a = a & ($urandom << $urandom_range(31, 0));
            if (i % 4 == 2) a = 32'h1 << $urandom_range(31, 0);
            ref_model(a, m_idx, m_zero, m_lat);
            run_op(a, lat, res, err);
            check($sformatf("rnd%0d_result", i), res, m_zero ? 32'd0 : m_idx);
            check($sformatf("rnd%0d_error", i), {31'd0, err}, {31'd0, m_zero});
            check($sformatf("rnd%0d_latency", i), lat, m_lat);
        end

        // Start pulsed again mid-scan must be ignored.
        @(negedge clk);
        arg   = 32'h4;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        arg   = 32'h1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        arg    = '0;
        nvalid = 0;
        cap_res = '1;
        cap_err = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (valid) begin
                nvalid++;
                cap_res = result;
                cap_err = error;
            end
            @(negedge clk);
        end
        check("restart_valid_count", nvalid, 32'd1);
        check("restart_result", cap_res, 32'd2);
        check("restart_error", {31'd0, cap_err}, 32'd0);

        // Reset mid-scan clears outputs at once and aborts the operation.
        @(negedge clk);
        arg   = 32'h10;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_result", result, 32'd0);
        check("midrst_error", {31'd0, error}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_valid", {31'd0, valid}, 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid) nvalid++;
        end
        check("midrst_no_valid", nvalid, 32'd0);
        ref_model(32'h10, m_idx, m_zero, m_lat);
        run_op(32'h10, lat, res, err);
        check("postrst_result", res, 32'd4);
        check("postrst_latency", lat, m_lat);

        // Back-to-back: start held high is accepted again in the IDLE cycle after DONE.
        @(negedge clk);
        arg   = 32'h20;
        start = 1'b1;
        gap   = 0;
        while (!valid && gap < 100) begin
            @(negedge clk);
            gap++;
        end
        check("b2b_first_result", result, 32'd5);
        arg = 32'h200;
        gap = 0;
        @(negedge clk);
        gap++;
        while (!valid && gap < 100) begin
            @(negedge clk);
            gap++;
        end
        start = 1'b0;
        ref_model(32'h200, m_idx, m_zero, m_lat);
        check("b2b_second_result", result, 32'd9);
        check("b2b_gap", gap, m_lat + 1);
        @(negedge clk);
        @(negedge clk);
        check("b2b_idle_after", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_lokalizacja_bitu
